// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_pkg
//  Description : Shared types and address helpers for the APB wait-state
//                slave memory (state encoding, lane count, word index and
//                address error decode).
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_mem_pkg;

    // Transfer FSM encoding
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Byte lanes for the default 32-bit data path
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned STRB_W     = DEF_DATA_W / 8;

    // Number of byte-offset bits inside one data word (8->0, 16->1, 32->2)
    function automatic int unsigned lane_bits(input int unsigned data_w);
        return (data_w == 8) ? 0 : ((data_w == 16) ? 1 : 2);
    endfunction

    // Word index addressed by a byte address
    function automatic logic [31:0] word_idx(input logic [31:0] addr,
                                             input int unsigned data_w);
        return addr >> lane_bits(data_w);
    endfunction

    // Misaligned byte address or word index beyond the implemented depth
    function automatic logic addr_err(input logic [31:0]  addr,
                                      input int unsigned  depth,
                                      input int unsigned  data_w);
        logic [31:0] mask;
        mask = (32'd1 << lane_bits(data_w)) - 32'd1;
        return ((addr & mask) != 32'd0) || (word_idx(addr, data_w) >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_array
//  Description : DEPTH x DATA_W storage with one byte-enabled write port and
//                one registered read port. The read register can be cleared
//                so the slave returns zero on an erroring access. Storage is
//                not reset; only the read register is.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [DATA_W/8-1:0] i_wr_strb,
    input  logic                i_rd_en,
    input  logic                i_rd_clr,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [DATA_W-1:0]   o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Byte-lane write: only lanes with their strobe set are updated
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (i_wr_strb[i]) begin
                    r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register: loads on a read, clears on an error, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end else if (i_rd_clr) begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave_ws.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave_ws
//  Description : APB slave memory, byte addressed and word organised, with
//                byte strobes, WAIT_CYCLES programmable wait states and an
//                error response on misaligned or out-of-range accesses.
//                Optional macro APB_MEM_PROT_EN: unprivileged writes
//                (pprot[0]=0) are rejected with pslverr and not committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_slave_ws #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic [2:0]          pprot,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    import apb_mem_pkg::*;

    localparam int unsigned c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  c_wait  = 4'(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic               r_err;
    logic               r_write;
    logic [c_idx_w-1:0] r_idx;

    logic [31:0]        w_paddr32;
    logic [31:0]        w_idx_full;
    logic               w_addr_err;
    logic               w_prot_err;
    logic               w_err;
    logic               w_setup;
    logic               w_last;
    logic               w_commit;
    logic               w_rd_en;
    logic               w_rd_clr;
    logic               w_unused;

    // Address decode on the live bus; results are only latched at setup
    assign w_paddr32  = 32'(paddr);
    assign w_idx_full = word_idx(w_paddr32, DATA_W);
    assign w_addr_err = addr_err(w_paddr32, DEPTH, DATA_W);

`ifdef APB_MEM_PROT_EN
    assign w_prot_err = pwrite & ~pprot[0];
    assign w_unused   = ^{pprot[2:1], w_idx_full};
`else
    assign w_prot_err = 1'b0;
    assign w_unused   = ^{pprot, w_idx_full};
`endif

    assign w_err    = w_addr_err | w_prot_err;
    assign w_setup  = (r_state == IDLE) && psel && !penable;
    assign w_last   = (r_state == ACCESS) && (r_cnt == c_wait);

    // Writes land at the end of the completion cycle; abandoned transfers never commit
    assign w_commit = w_last && psel && r_write && !r_err;

    // Reads sample storage at setup; any erroring setup zeroes prdata
    assign w_rd_en  = w_setup && !pwrite && !w_err;
    assign w_rd_clr = w_setup && w_err;

    // State register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and completion outputs from the registered state
    always_comb begin
        w_state_nxt = r_state;
        pready      = 1'b0;
        pslverr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                pready  = (r_cnt == c_wait);
                pslverr = (r_cnt == c_wait) && r_err;
                if (!psel || (r_cnt == c_wait)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Wait counter and per-transfer attributes latched at setup
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
        end else if (w_setup) begin
            r_cnt   <= 4'd0;
            r_err   <= w_err;
            r_write <= pwrite;
            r_idx   <= w_idx_full[c_idx_w-1:0];
        end else if ((r_state == ACCESS) && (r_cnt < c_wait)) begin
            r_cnt   <= r_cnt + 4'd1;
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_idx_w)
    ) u_array (
        .clk       (pclk),
        .rst       (preset),
        .i_wr_en   (w_commit),
        .i_wr_idx  (r_idx),
        .i_wr_data (pwdata),
        .i_wr_strb (pstrb),
        .i_rd_en   (w_rd_en),
        .i_rd_clr  (w_rd_clr),
        .i_rd_idx  (w_idx_full[c_idx_w-1:0]),
        .o_rd_data (prdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mem_slave_ws
//  Description : Directed self-checking bench for apb_mem_slave_ws. Two
//                instances share the bus: one with zero wait states and one
//                with three. Honours APB_MEM_PROT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave_ws;

    logic        pclk    = 1'b0;
    logic        preset  = 1'b1;
    logic        psel0   = 1'b0;
    logic        psel3   = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [15:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [3:0]  pstrb   = '0;
    logic [2:0]  pprot   = '0;

    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] rd;
    logic        er;
    int          wt;

    always #5 pclk = ~pclk;

    apb_mem_slave_ws #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_mem_slave_ws #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer; waits = access cycles seen with pready low
    task automatic xfer(input bit sel3, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err, output int waits);
        @(negedge pclk);
        psel0 = !sel3; psel3 = sel3; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        while (((sel3 ? pready3 : pready0) !== 1'b1) && (waits < 20)) begin
            @(negedge pclk);
            waits++;
        end
        rdata = sel3 ? prdata3 : prdata0;
        err   = sel3 ? pslverr3 : pslverr0;
        @(negedge pclk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_prdata0",  prdata0,  32'h0);
        check("rst_pready0",  32'(pready0),  32'h0);
        check("rst_pslverr0", 32'(pslverr0), 32'h0);
        check("rst_prdata3",  prdata3,  32'h0);
        check("rst_pready3",  32'(pready3),  32'h0);
        preset = 1'b0;

        // Zero wait states: write then read back
        xfer(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, wt);
        check("w0_waits", 32'(wt), 32'd0);
        check("w0_err",   32'(er), 32'd0);
        xfer(0, 0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("r0_waits", 32'(wt), 32'd0);
        check("r0_data",  rd, 32'hDEADBEEF);
        check("r0_err",   32'(er), 32'd0);

        // Three wait states: pready on the fourth access cycle
        xfer(1, 1, 16'h0020, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, wt);
        check("w3_waits", 32'(wt), 32'd3);
        xfer(1, 0, 16'h0020, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("r3_waits", 32'(wt), 32'd3);
        check("r3_data",  rd, 32'hCAFEF00D);

        // Byte strobes
        xfer(0, 1, 16'h0030, 32'h11223344, 4'hF, 3'b001, rd, er, wt);
        xfer(0, 1, 16'h0030, 32'hAABBCCDD, 4'b0101, 3'b001, rd, er, wt);
        xfer(0, 0, 16'h0030, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("strb_data", rd, 32'h11BB33DD);

        // Zero strobes: no-op, no error
        xfer(0, 1, 16'h0010, 32'h00000000, 4'h0, 3'b001, rd, er, wt);
        check("strb0_err", 32'(er), 32'd0);
        xfer(0, 0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("strb0_data", rd, 32'hDEADBEEF);

        // Error responses
        xfer(0, 0, 16'h1002, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("mis_err",  32'(er), 32'd1);
        check("mis_data", rd, 32'h0);
        xfer(0, 0, 16'h0010, 32'h0, 4'h0, 3'b000, rd, er, wt);
        xfer(0, 0, 16'h1000, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("oor_err",  32'(er), 32'd1);
        check("oor_data", rd, 32'h0);
        xfer(0, 1, 16'h0000, 32'h0BADF00D, 4'hF, 3'b001, rd, er, wt);
        xfer(0, 1, 16'h1000, 32'h12345678, 4'hF, 3'b001, rd, er, wt);
        check("oorw_err", 32'(er), 32'd1);
        xfer(0, 0, 16'h0000, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("oorw_mem", rd, 32'h0BADF00D);
        check("ok_err",   32'(er), 32'd0);

        // Reset during the second access cycle of a write
        xfer(1, 1, 16'h0040, 32'h01020304, 4'hF, 3'b001, rd, er, wt);
        xfer(1, 0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("pre_rst_data", rd, 32'h01020304);
        @(negedge pclk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'h0040; pwdata = 32'h5A5A5A5A; pstrb = 4'hF; pprot = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        check("acc1_pready", 32'(pready3), 32'd0);
        @(negedge pclk);
        preset = 1'b1;
        #1;
        check("mid_rst_pready",  32'(pready3),  32'd0);
        check("mid_rst_pslverr", 32'(pslverr3), 32'd0);
        check("mid_rst_prdata",  prdata3, 32'h0);
        @(negedge pclk);
        preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        xfer(1, 0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("post_rst_data", rd, 32'h01020304);

        // Protection attribute handling
        xfer(0, 1, 16'h0050, 32'h00000077, 4'hF, 3'b001, rd, er, wt);
        xfer(0, 1, 16'h0050, 32'h00000001, 4'hF, 3'b000, rd, er, wt);
`ifdef APB_MEM_PROT_EN
        check("prot0_err", 32'(er), 32'd1);
        xfer(0, 0, 16'h0050, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("prot0_mem", rd, 32'h00000077);
        xfer(0, 1, 16'h0050, 32'h00000001, 4'hF, 3'b001, rd, er, wt);
        check("prot1_err", 32'(er), 32'd0);
        xfer(0, 0, 16'h0050, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("prot1_mem", rd, 32'h00000001);
`else
        check("noprot_err", 32'(er), 32'd0);
        xfer(0, 0, 16'h0050, 32'h0, 4'h0, 3'b000, rd, er, wt);
        check("noprot_mem", rd, 32'h00000001);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
